// File: rtl/tt_um_digital_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_digital_clock
//  Description : 24-hour HH:MM:SS clock with 1 Hz prescaler, fast-run mode,
//                minute/hour set buttons and a BCD / 7-segment field display.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_digital_clock #(
    parameter int CLK_HZ = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,     // active-high asynchronous reset
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                   c_presc_w    = $clog2(CLK_HZ);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_HZ - 1);

    // Time held as packed BCD {tens, units}
    logic [7:0]           r_sec;
    logic [7:0]           r_min;
    logic [7:0]           r_hr;
    logic [c_presc_w-1:0] r_presc;

    logic r_min_s1, r_min_s2, r_min_prev;
    logic r_hr_s1,  r_hr_s2,  r_hr_prev;

    logic       w_run, w_fast, w_seg_mode;
    logic [1:0] w_sel;
    logic       w_tick, w_min_edge, w_hr_edge, w_set_any;
    logic [7:0] w_field;
    logic [6:0] w_seg;
    logic       w_unused;

    assign w_run      = ui_in[0];
    assign w_fast     = ui_in[1];
    assign w_sel      = ui_in[5:4];
    assign w_seg_mode = ui_in[6];
    assign w_unused   = &{1'b0, ena, uio_in, ui_in[7]};

    assign w_min_edge = r_min_s2 & ~r_min_prev;
    assign w_hr_edge  = r_hr_s2  & ~r_hr_prev;
    assign w_set_any  = w_min_edge | w_hr_edge;

    // Tick is forced low while reset is held so status reads all-zero then
    assign w_tick = ~rst_n & w_run & (w_fast | (r_presc == c_presc_last));

    // BCD increment with wrap to 00 after the given maximum
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Button synchronizers and previous-value flops for rising-edge detect
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_min_s1   <= 1'b0;
            r_min_s2   <= 1'b0;
            r_min_prev <= 1'b0;
            r_hr_s1    <= 1'b0;
            r_hr_s2    <= 1'b0;
            r_hr_prev  <= 1'b0;
        end else begin
            r_min_s1   <= ui_in[2];
            r_min_s2   <= r_min_s1;
            r_min_prev <= r_min_s2;
            r_hr_s1    <= ui_in[3];
            r_hr_s2    <= r_hr_s1;
            r_hr_prev  <= r_hr_s2;
        end
    end

    // Prescaler: counts only in normal run mode, restarts on a minute set
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_presc <= '0;
        end else if (w_min_edge) begin
            r_presc <= '0;
        end else if (w_run) begin
            if (w_fast || (r_presc == c_presc_last))
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;
        end
    end

    // Time registers: button sets take priority over (and swallow) a tick
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sec <= 8'h00;
            r_min <= 8'h00;
            r_hr  <= 8'h00;
        end else if (w_set_any) begin
            if (w_min_edge) begin
                r_min <= bcd_inc(r_min, 8'h59);
                r_sec <= 8'h00;
            end
            if (w_hr_edge)
                r_hr <= bcd_inc(r_hr, 8'h23);
        end else if (w_tick) begin
            r_sec <= bcd_inc(r_sec, 8'h59);
            if (r_sec == 8'h59) begin
                r_min <= bcd_inc(r_min, 8'h59);
                if (r_min == 8'h59)
                    r_hr <= bcd_inc(r_hr, 8'h23);
            end
        end
    end

    // Field select and 7-segment decode of the selected units digit
    always_comb begin
        w_field = r_hr;
        case (w_sel)
            2'b00:   w_field = r_sec;
            2'b01:   w_field = r_min;
            default: w_field = r_hr;
        endcase
        w_seg = 7'h00;
        case (w_field[3:0])
            4'd0:    w_seg = 7'h3F;
            4'd1:    w_seg = 7'h06;
            4'd2:    w_seg = 7'h5B;
            4'd3:    w_seg = 7'h4F;
            4'd4:    w_seg = 7'h66;
            4'd5:    w_seg = 7'h6D;
            4'd6:    w_seg = 7'h7D;
            4'd7:    w_seg = 7'h07;
            4'd8:    w_seg = 7'h7F;
            4'd9:    w_seg = 7'h6F;
            default: w_seg = 7'h00;
        endcase
    end

    assign uo_out  = w_seg_mode ? {r_sec[0], w_seg} : w_field;
    assign uio_out = {5'b00000, (r_hr >= 8'h12), r_sec[0], w_tick};
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_digital_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_um_digital_clock
//  Description : Scoreboard bench for tt_um_digital_clock (CLK_HZ = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_digital_clock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic       is_uio;
        logic [1:0] sel;
        logic       seg;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];

    tt_um_digital_clock #(.CLK_HZ(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_uo(input string tag, input logic [1:0] sel, input logic seg,
                           input logic [7:0] exp);
        exp_t e;
        e.tag = tag; e.is_uio = 1'b0; e.sel = sel; e.seg = seg; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_uio(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag; e.is_uio = 1'b1; e.sel = 2'b00; e.seg = 1'b0; e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pop every queued expectation, steer the display to it and compare
    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!e.is_uio) begin
                ui_in[5:4] = e.sel;
                ui_in[6]   = e.seg;
            end
            #1;
            if (e.is_uio) check(e.tag, uio_out, e.exp);
            else          check(e.tag, uo_out, e.exp);
        end
    endtask

    task automatic pulse(input int b);
        ui_in[b] = 1'b1;
        cycles(2);
        ui_in[b] = 1'b0;
        cycles(3);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h03;            // run=1 fast=1 sel=00 seg=0
        rst_n  = 1'b1;
        cycles(3);

        // Reset state
        push_uo("rst_bcd", 2'b00, 1'b0, 8'h00);
        push_uo("rst_seg", 2'b00, 1'b1, 8'h3F);
        push_uio("rst_uio", 8'h00);
        drain();
        check("uio_oe", uio_oe, 8'hFF);

        // Fast run from reset
        ui_in[6] = 1'b0; ui_in[5:4] = 2'b00;
        rst_n = 1'b0;
        cycles(10);
        push_uo("fast_10", 2'b00, 1'b0, 8'h10);
        drain();
        cycles(49);
        push_uo("fast_59", 2'b00, 1'b0, 8'h59);
        drain();
        cycles(1);
        push_uo("wrap_sec", 2'b00, 1'b0, 8'h00);
        push_uo("carry_min", 2'b01, 1'b0, 8'h01);
        drain();
        ui_in[0] = 1'b0;

        // Normal mode with CLK_HZ=4: one tick every 4th cycle
        cycles(1);
        ui_in[1] = 1'b0; ui_in[0] = 1'b1;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ticks += int'(uio_out[0]);
        end
        check("tick_count", 8'(ticks), 8'd3);
        push_uo("slow_12", 2'b00, 1'b0, 8'h03);
        drain();
        cycles(2);
        ui_in[0] = 1'b0;
        cycles(5);
        push_uo("freeze_sec", 2'b00, 1'b0, 8'h03);
        push_uio("freeze_uio", 8'h02);
        drain();
        ui_in[0] = 1'b1;
        cycles(1);
        push_uio("resume_tick", 8'h03);
        drain();
        cycles(1);
        push_uo("resume_sec", 2'b00, 1'b0, 8'h04);
        push_uio("resume_uio", 8'h00);
        drain();

        // Reset mid-count
        ui_in[1] = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        push_uo("midrst_sec", 2'b00, 1'b0, 8'h00);
        push_uo("midrst_min", 2'b01, 1'b0, 8'h00);
        push_uio("midrst_uio", 8'h00);
        drain();
        cycles(2);
        ui_in[5:4] = 2'b00; ui_in[6] = 1'b0;
        rst_n = 1'b0;
        cycles(37);
        ui_in[0] = 1'b0;
        push_uo("at_37", 2'b00, 1'b0, 8'h37);
        drain();

        // set_min held high 5 cycles: one increment at edge 3
        ui_in[2] = 1'b1;
        cycles(2);
        push_uo("setmin_lat2", 2'b01, 1'b0, 8'h00);
        drain();
        cycles(1);
        push_uo("setmin_min", 2'b01, 1'b0, 8'h01);
        push_uo("setmin_sec", 2'b00, 1'b0, 8'h00);
        drain();
        cycles(2);
        ui_in[2] = 1'b0;
        cycles(3);
        push_uo("setmin_once", 2'b01, 1'b0, 8'h01);
        drain();
        for (int i = 0; i < 59; i++) pulse(2);
        push_uo("setmin_wrap", 2'b01, 1'b0, 8'h00);
        push_uo("setmin_hr", 2'b10, 1'b0, 8'h00);
        drain();

        // set_hr pulses and pm flag
        for (int i = 1; i <= 24; i++) begin
            pulse(3);
            if (i == 11) push_uio("pm_11", 8'h00);
            if (i == 12) begin
                push_uio("pm_12", 8'h04);
                push_uo("hr_12", 2'b10, 1'b0, 8'h12);
                push_uo("hr_12_sel3", 2'b11, 1'b0, 8'h12);
            end
            drain();
        end
        push_uo("hr_wrap", 2'b10, 1'b0, 8'h00);
        push_uio("pm_wrap", 8'h00);
        drain();

        // Both buttons together
        ui_in[3:2] = 2'b11;
        cycles(3);
        push_uo("both_min", 2'b01, 1'b0, 8'h01);
        push_uo("both_hr", 2'b10, 1'b0, 8'h01);
        drain();
        ui_in[3:2] = 2'b00;
        cycles(3);

        // Day rollover 23:59:59 -> 00:00:00
        for (int i = 0; i < 22; i++) pulse(3);
        for (int i = 0; i < 58; i++) pulse(2);
        ui_in[0] = 1'b1;
        cycles(59);
        ui_in[0] = 1'b0;
        push_uo("eod_hr", 2'b10, 1'b0, 8'h23);
        push_uo("eod_min", 2'b01, 1'b0, 8'h59);
        push_uo("eod_sec", 2'b00, 1'b0, 8'h59);
        push_uio("eod_uio", 8'h06);
        drain();
        ui_in[0] = 1'b1;
        cycles(1);
        ui_in[0] = 1'b0;
        push_uo("day_hr", 2'b10, 1'b0, 8'h00);
        push_uo("day_min", 2'b01, 1'b0, 8'h00);
        push_uo("day_sec", 2'b00, 1'b0, 8'h00);
        push_uio("day_uio", 8'h00);
        drain();

        // Hour tens carry 09:59:00 + 60 ticks -> 10:00:00
        for (int i = 0; i < 9; i++) pulse(3);
        for (int i = 0; i < 59; i++) pulse(2);
        ui_in[0] = 1'b1;
        cycles(60);
        ui_in[0] = 1'b0;
        push_uo("carry_hr", 2'b10, 1'b0, 8'h10);
        push_uo("carry_min0", 2'b01, 1'b0, 8'h00);
        push_uo("carry_sec0", 2'b00, 1'b0, 8'h00);
        drain();

        // 7-segment mode
        rst_n = 1'b1;
        cycles(2);
        ui_in[0] = 1'b1;
        rst_n = 1'b0;
        cycles(7);
        ui_in[0] = 1'b0;
        push_uo("seg_07", 2'b00, 1'b1, 8'h87);
        push_uo("seg_min0", 2'b01, 1'b1, 8'hBF);
        push_uio("seg_uio", 8'h02);
        drain();
        ui_in[0] = 1'b1;
        cycles(1);
        ui_in[0] = 1'b0;
        push_uo("seg_08", 2'b00, 1'b1, 8'h7F);
        push_uo("bcd_08", 2'b00, 1'b0, 8'h08);
        drain();
        check("uio_oe_end", uio_oe, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
